// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the command-word RAM initiator: default payload
// width, the 2-bit opcodes carried in the top bits of each command word,
// and the FSM state encodings.
package ram_cmd_pkg;

  localparam int DEF_ADDR_SIZE = 8;

  localparam logic [1:0] OP_WR_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR_DATA  = 2'b01;
  localparam logic [1:0] OP_RD_ADDR  = 2'b10;
  localparam logic [1:0] OP_RD_FETCH = 2'b11;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ADDR  = 3'd1;
  localparam logic [2:0] WR_DATA  = 3'd2;
  localparam logic [2:0] RD_ADDR  = 3'd3;
  localparam logic [2:0] RD_FETCH = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] RESP     = 3'd6;

endpackage

// File: rtl/ram_cmd_master.sv
// Initiator for the single-port command RAM. Turns one request into the
// 2-word command sequence (address word, then data or fetch word), collects
// read data and flags a timeout if the RAM never raises its read valid.
// Optional build macro: RAM_CMD_ADDR_CACHE_EN (skip the address word when the
// previous write/read already targeted the same address).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// WR_ADDR  | driving {00,addr}
// WR_DATA  | driving {01,wdata}
// RD_ADDR  | driving {10,addr}
// RD_FETCH | driving {11,0}
// RD_WAIT  | sampling ram_tx_valid, counting toward the timeout
// RESP     | rsp_valid high for one cycle
module ram_cmd_master
  import ram_cmd_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE+1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  logic [2:0]           state;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [TO_W-1:0]      to_cnt;
  logic [TO_W-1:0]      to_nxt;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 unused_dout_hi;

  // Ready only in IDLE and never while reset is held.
  assign req_ready      = (state == IDLE) && rst_n;
  assign to_nxt         = to_cnt + 1'b1;
  assign unused_dout_hi = ^ram_dout[ADDR_SIZE+1:ADDR_SIZE];

`ifdef RAM_CMD_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] last_wr_addr;
  logic [ADDR_SIZE-1:0] last_rd_addr;
  logic                 last_wr_vld;
  logic                 last_rd_vld;

  assign wr_hit = last_wr_vld && (last_wr_addr == req_addr);
  assign rd_hit = last_rd_vld && (last_rd_addr == req_addr);

  // Remember the address last sent to the RAM for each direction; the
  // address word goes out on the same edge that accepts a missing request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_wr_addr <= '0;
      last_rd_addr <= '0;
      last_wr_vld  <= 1'b0;
      last_rd_vld  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      if (req_we && !wr_hit) begin
        last_wr_addr <= req_addr;
        last_wr_vld  <= 1'b1;
      end
      if (!req_we && !rd_hit) begin
        last_rd_addr <= req_addr;
        last_rd_vld  <= 1'b1;
      end
    end
  end
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  // Sequencer: outputs are registered alongside the next state, so each
  // word is on the bus during the cycle the FSM sits in the sending state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wdata_q      <= '0;
      to_cnt       <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wdata_q      <= req_wdata;
            ram_rx_valid <= 1'b1;
            if (req_we) begin
              if (wr_hit) begin
                state   <= WR_DATA;
                ram_din <= {OP_WR_DATA, req_wdata};
              end else begin
                state   <= WR_ADDR;
                ram_din <= {OP_WR_ADDR, req_addr};
              end
            end else begin
              to_cnt <= '0;
              if (rd_hit) begin
                state   <= RD_FETCH;
                ram_din <= {OP_RD_FETCH, {ADDR_SIZE{1'b0}}};
              end else begin
                state   <= RD_ADDR;
                ram_din <= {OP_RD_ADDR, req_addr};
              end
            end
          end
        end
        WR_ADDR: begin
          state        <= WR_DATA;
          ram_rx_valid <= 1'b1;
          ram_din      <= {OP_WR_DATA, wdata_q};
        end
        WR_DATA: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RD_ADDR: begin
          state        <= RD_FETCH;
          ram_rx_valid <= 1'b1;
          ram_din      <= {OP_RD_FETCH, {ADDR_SIZE{1'b0}}};
        end
        RD_FETCH: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // ram_tx_valid is sticky in the RAM, so it is looked at only here.
          if (ram_tx_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_dout[ADDR_SIZE-1:0];
          end else begin
            to_cnt <= to_nxt;
            if (to_nxt == TO_W'(TIMEOUT)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Bench for ram_cmd_master with a behavioural command RAM. Each request's
// expected word trace and response are pushed to a scoreboard queue when
// the request is driven and popped when the response comes back.
module tb_ram_cmd_master;

  localparam int AW  = 8;
  localparam int CW  = AW + 2;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [AW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [CW-1:0] ram_din;
  logic          ram_rx_valid;
  logic [CW-1:0] ram_dout;
  logic          ram_tx_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          got;
    logic          rdy0;
    logic          busy_rdy;
    logic [2:0]    n;
    logic [CW-1:0] w0;
    logic [5:0]    c0;
    logic [CW-1:0] w1;
    logic [5:0]    c1;
    logic [5:0]    rc;
    logic          err;
    logic [AW-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];

  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  // Behavioural command RAM: sticky read valid, data one cycle after fetch.
  logic [AW-1:0] mem [256];
  logic [AW-1:0] ram_waddr = '0;
  logic [AW-1:0] ram_raddr = '0;
  logic          tx_sticky;
  logic          ram_mute = 1'b0;

  assign ram_tx_valid = tx_sticky & ~ram_mute;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      tx_sticky <= 1'b0;
      ram_dout  <= '0;
    end else if (ram_rx_valid) begin
      case (ram_din[CW-1:AW])
        2'b00: ram_waddr <= ram_din[AW-1:0];
        2'b01: mem[ram_waddr] <= ram_din[AW-1:0];
        2'b10: ram_raddr <= ram_din[AW-1:0];
        default: begin
          ram_dout  <= {2'b11, mem[ram_raddr]};
          tx_sticky <= 1'b1;
        end
      endcase
    end
  end

`ifdef RAM_CMD_ADDR_CACHE_EN
  logic [AW-1:0] m_wr_addr = '0;
  logic [AW-1:0] m_rd_addr = '0;
  bit            m_wr_vld  = 1'b0;
  bit            m_rd_vld  = 1'b0;
`endif

  task automatic model_reset();
`ifdef RAM_CMD_ADDR_CACHE_EN
    m_wr_vld = 1'b0;
    m_rd_vld = 1'b0;
`endif
  endtask

  // Expected trace: cycle 0 = accept cycle; words and response cycles relative to it.
  task automatic predict(input bit we, input logic [AW-1:0] addr,
                         input logic [AW-1:0] wdata, input logic [AW-1:0] rdata,
                         input bit tmo);
    txn_t e;
    bit hit;
    e = '0;
    e.got = 1'b1;
    e.rdy0 = 1'b1;
    hit = 1'b0;
`ifdef RAM_CMD_ADDR_CACHE_EN
    hit = we ? (m_wr_vld && m_wr_addr == addr) : (m_rd_vld && m_rd_addr == addr);
    if (!hit) begin
      if (we) begin m_wr_addr = addr; m_wr_vld = 1'b1; end
      else begin m_rd_addr = addr; m_rd_vld = 1'b1; end
    end
`endif
    if (we) begin
      if (hit) begin
        e.n = 3'd1; e.w0 = {2'b01, wdata}; e.c0 = 6'd1; e.rc = 6'd2;
      end else begin
        e.n = 3'd2; e.w0 = {2'b00, addr}; e.c0 = 6'd1;
        e.w1 = {2'b01, wdata}; e.c1 = 6'd2; e.rc = 6'd3;
      end
    end else begin
      if (hit) begin
        e.n = 3'd1; e.w0 = {2'b11, 8'h00}; e.c0 = 6'd1;
      end else begin
        e.n = 3'd2; e.w0 = {2'b10, addr}; e.c0 = 6'd1;
        e.w1 = {2'b11, 8'h00}; e.c1 = 6'd2;
      end
      e.rc    = tmo ? 6'((hit ? 2 : 3) + TMO) : (hit ? 6'd3 : 6'd4);
      e.err   = tmo;
      e.rdata = tmo ? 8'h00 : rdata;
    end
    exp_q.push_back(e);
  endtask

  // Drive one request at a negedge and record what the DUT does, bounded.
  // With hold set, req_valid stays high with junk fields while busy.
  task automatic run_req(input bit we, input logic [AW-1:0] addr,
                         input logic [AW-1:0] wdata, input bit hold, output txn_t o);
    o = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    o.rdy0 = req_ready;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin req_we = ~we; req_addr = 8'hEE; req_wdata = 8'h77; end
        else req_valid = 1'b0;
      end
      if (req_ready) o.busy_rdy = 1'b1;
      if (ram_rx_valid) begin
        if (o.n == 3'd0) begin o.w0 = ram_din; o.c0 = 6'(k); end
        else if (o.n == 3'd1) begin o.w1 = ram_din; o.c1 = 6'(k); end
        if (o.n != 3'd7) o.n = o.n + 3'd1;
      end
      if (rsp_valid) begin
        o.got = 1'b1; o.rc = 6'(k); o.err = rsp_err; o.rdata = rsp_rdata;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        if (ram_rx_valid || rsp_valid) o.n = 3'd7;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got=%b exp=0", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got=%b exp=0", rsp_valid); end
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got=%b exp=0", rsp_err); end
    if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_rdata: got=%h exp=00", rsp_rdata); end
    if (ram_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got=%b exp=0", ram_rx_valid); end
    if (ram_din !== 10'h000) begin n_fail++; $display("FAIL rst_ram_din: got=%h exp=000", ram_din); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got=%b exp=1", req_ready); end
  endtask

  task automatic test_write();
    txn_t o, e;
    predict(1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0);
    run_req(1'b1, 8'h3C, 8'hA5, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL write_3c: got=%h exp=%h", o, e); end
  endtask

  task automatic test_read();
    txn_t o, e;
    predict(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0);
    run_req(1'b0, 8'h3C, 8'h00, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL read_3c: got=%h exp=%h", o, e); end
  endtask

  task automatic test_timeout();
    txn_t o, e;
    ram_mute = 1'b1;
    predict(1'b0, 8'h55, 8'h00, 8'h00, 1'b1);
    run_req(1'b0, 8'h55, 8'h00, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL read_timeout: got=%h exp=%h", o, e); end
    ram_mute = 1'b0;
  endtask

  task automatic test_sticky();
    txn_t o, e;
    predict(1'b1, 8'h10, 8'h5A, 8'h00, 1'b0);
    run_req(1'b1, 8'h10, 8'h5A, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL sticky_write: got=%h exp=%h", o, e); end
    predict(1'b0, 8'h10, 8'h00, 8'h5A, 1'b0);
    run_req(1'b0, 8'h10, 8'h00, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL sticky_read: got=%h exp=%h", o, e); end
  endtask

  task automatic test_back_to_back();
    txn_t o, e;
    for (int i = 0; i < 2; i++) begin
      predict(1'b1, 8'(8'h60 + i), 8'(8'h90 + i), 8'h00, 1'b0);
      run_req(1'b1, 8'(8'h60 + i), 8'(8'h90 + i), 1'b0, o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_write%0d: got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_busy_ignored();
    txn_t o, e;
    predict(1'b1, 8'h44, 8'h66, 8'h00, 1'b0);
    run_req(1'b1, 8'h44, 8'h66, 1'b1, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL busy_ignored: got=%h exp=%h", o, e); end
  endtask

  task automatic test_reset_mid();
    txn_t o, e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h33;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_rx_valid !== 1'b1 || ram_din !== 10'h133) begin
      n_fail++; $display("FAIL mid_wr_data_word: got=%b/%h exp=1/133", ram_rx_valid, ram_din);
    end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks += 3;
    if (ram_rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rx_valid: got=%b exp=0", ram_rx_valid); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rsp_valid: got=%b exp=0", rsp_valid); end
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got=%b exp=0", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got=%b exp=1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_rsp: got=%b exp=0", rsp_valid); end
    if (ram_rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_rx: got=%b exp=0", ram_rx_valid); end
    predict(1'b1, 8'h3C, 8'h11, 8'h00, 1'b0);
    run_req(1'b1, 8'h3C, 8'h11, 1'b0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL post_reset_write: got=%h exp=%h", o, e); end
  endtask

  task automatic test_addr_cache();
    txn_t o, e;
    logic [AW-1:0] a_tab [5] = '{8'h07, 8'h07, 8'h08, 8'h07, 8'h07};
    logic [AW-1:0] d_tab [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    bit            w_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      predict(w_tab[i], a_tab[i], d_tab[i], 8'h02, 1'b0);
      run_req(w_tab[i], a_tab[i], d_tab[i], 1'b0, o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL cache_step%0d: got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_sticky();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    test_addr_cache();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
